// File: rtl/window_sum_ctrl_if.sv
// Streaming interface for window_sum_ctrl.
// Groups the sample input handshake (in_valid/in_data/in_ready) and the
// window-sum output handshake (out_valid/out_data/out_ready).
//   slave  : the window_sum_ctrl side (consumes samples, produces sums)
//   master : the environment side (sample source plus downstream consumer)
interface window_sum_ctrl_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/window_sum_ctrl.sv
// Sliding-window sum controller: emits the sum (mod 2**DW) of the last
// 2**N accepted samples, with valid/ready handshakes on both sides,
// warm-up tracking and a sequenced buffer clear.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear request (pulse or level)
//   s     - stream interface (slave modport): samples in, window sums out
//   fill  - number of valid samples in the window, 0..2**N
//   busy  - high while the sample buffer is being cleared
module window_sum_ctrl #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  window_sum_ctrl_if.slave   s,
  output logic [N:0]         fill,
  output logic               busy
);

  localparam int unsigned W = 2**N;
  localparam logic [N:0] FILL_LAST = {1'b0, {N{1'b1}}};

  typedef enum logic [1:0] {CLEAR, FILL, RUN} state_t;

  state_t        state_q;
  logic [N-1:0]  cidx_q;
  logic [N-1:0]  wptr_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;
  logic [N:0]    fill_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] mem_q [W];

  logic in_ready;
  logic accept;
  logic produce;

  // The output register can take a new sum when it is empty or being drained
  // this cycle; clr blocks any same-cycle sample.
  always_comb begin
    in_ready = (state_q != CLEAR) && !clr && (!out_valid_q || s.out_ready);
    accept   = s.in_valid && in_ready;
    // The accept that completes the window is the first one to produce a sum.
    produce  = accept && ((state_q == RUN) || (fill_q == FILL_LAST));
    // Oldest sample drops out as the new one enters; modulo arithmetic keeps
    // the running sum exact mod 2**DW.
    acc_d    = acc_q + s.in_data - mem_q[wptr_q];
  end

  // Sample buffer: no reset, every entry is zeroed by the CLEAR sequence.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cidx_q] <= '0;
    end else if (accept) begin
      mem_q[wptr_q] <= s.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      cidx_q      <= '0;
      wptr_q      <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr) begin
            cidx_q <= '0;
          end else if (cidx_q == '1) begin
            cidx_q  <= '0;
            acc_q   <= '0;
            fill_q  <= '0;
            wptr_q  <= '0;
            state_q <= FILL;
          end else begin
            cidx_q <= cidx_q + N'(1);
          end
        end
        FILL, RUN: begin
          if (clr) begin
            state_q     <= CLEAR;
            cidx_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
          end else begin
            if (accept) begin
              acc_q  <= acc_d;
              wptr_q <= wptr_q + N'(1);
              if (state_q == FILL) begin
                fill_q <= fill_q + (N+1)'(1);
              end
            end
            // A new sum overrides the drain of the old one in the same cycle.
            if (produce) begin
              out_valid_q <= 1'b1;
              out_data_q  <= acc_d;
              state_q     <= RUN;
            end else if (out_valid_q && s.out_ready) begin
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign fill        = fill_q;
  assign busy        = (state_q == CLEAR);

endmodule
